approx_level_ctrl: RTL and testbench
====================================

// Module: approx_level_ctrl
// PURPOSE
//  Generates approx_level[2:0] for the approximate Sklansky prefix-carry tree in the adder datapath.
//  Runs in one of two modes:
//  - FIXED: the level comes straight from a config write.
//  - ADAPTIVE: the block checks adder results against an exact a+b, counts mismatches per window,
//    and moves the level one step up or down a 4-step ladder.
//  A level change is applied only when the core grants it through upd_allow.
// PARAMETERS
//  WIN_LOG2  8   window length = 2**WIN_LOG2 accepted samples
//  ERR_W     16  width of error counter, thresholds and win_err
// PORTS
//  clk           in   1      core clock
//  rst           in   1      asynchronous, active-high reset
//  cfg_we        in   1      config write strobe (single cycle)
//  cfg_mode      in   1      0=FIXED, 1=ADAPTIVE
//  cfg_level     in   2      ladder index to load
//  cfg_hi_th     in   ERR_W  step-down threshold (error count)
//  cfg_lo_th     in   ERR_W  step-up threshold (error count)
//  smp_valid     in   1      adder sample present this cycle
//  smp_a, smp_b  in   32     adder operands
//  smp_sum       in   32     approximate adder result
//  upd_allow     in   1      core pipeline drained, level may change
//  approx_level  out  3      to prefix tree (bit0 rows1-3, bit1 row4, bit2 row5)
//  level_idx     out  2      current ladder index
//  level_chg     out  1      1-cycle pulse in the first cycle a new level is visible
//  win_err       out  ERR_W  mismatch count of last completed window
// BEHAVIOUR
//  - Ladder idx->approx_level: 0->3'b000 (exact), 1->3'b001, 2->3'b011, 3->3'b111; registered.
//  - Reset: idx=0, approx_level=0, level_chg=0, win_err=0.
//  - Reset also clears: mode=FIXED, state=FIXED, thresholds=0, all counters and pipeline valids.
//  - States: FIXED, MONITOR, PEND.
//  - Stage 1: register s1_v=smp_valid, s1_mis=((smp_a+smp_b) mod 2^32 != smp_sum).
//    Drop the sample (s1_v=0) unless state=MONITOR.
//  - Stage 2 (MONITOR, s1_v=1): err_acc += s1_mis, saturating at 2^ERR_W-1; smp_cnt++.
//  - Window end is the stage-2 update with smp_cnt==2^WIN_LOG2-1:
//    - win_err <= saturated err_acc+s1_mis; err_acc, smp_cnt <= 0.
//    - Decision uses that value E:
//      - E>cfg_hi_th -> target=idx-1;
//      - else E<cfg_lo_th -> target=idx+1;
//      - else hold. hi compare takes precedence.
//    - Target outside 0..3, or hold -> stay in MONITOR, no change, no pulse.
//    - Otherwise latch target and go to PEND.
//  - PEND: samples dropped, counters held at 0.
//    When upd_allow=1: idx<=target, state<=MONITOR, level_chg=1 next cycle.
//    Waits indefinitely while upd_allow=0.
//  - Timing:
//    - Last sample of a window accepted in cycle t.
//    - win_err valid and state=PEND in cycle t+2.
//    - With upd_allow=1 in cycle t+2, new approx_level and level_chg=1 in cycle t+3.
//  - cfg_we (any state) has highest priority:
//    - Loads thresholds and mode; idx<=cfg_level.
//    - Clears err_acc, smp_cnt, s1_v and any pending target.
//    - Next state: FIXED if cfg_mode=0, else MONITOR.
//    - level_chg pulses next cycle only if idx actually changed. cfg_we ignores upd_allow.
//  - cfg_we in the same cycle as a window end: config wins, window discarded, win_err unchanged.
//  - FIXED: samples ignored; win_err holds its last value.
//  - Async reset mid-PEND or mid-window: all state returns to reset values immediately.
// TESTING
//  - Reset: assert rst mid-window -> approx_level=000, level_idx=0, level_chg=0, win_err=0 with no clock edge.
//  - FIXED: cfg_we mode=0 level=2 -> approx_level=011 next cycle, one level_chg pulse.
//    Rewriting level=2 -> no pulse.
//  - Step down (WIN_LOG2=2, start idx=3, hi=2, lo=0): 4 mismatching samples, upd_allow=1 ->
//    win_err=4, idx=2, approx_level=011 at t+3, one pulse.
//  - Step up (idx=1, lo=1): 4 exact samples -> win_err=0, idx=2.
//    Repeat from idx=3 -> no change, no pulse.
//  - Pending: upd_allow=0 for 20 cycles with samples streaming -> stays PEND, level unchanged,
//    counters 0; upd_allow=1 -> change applied next cycle.
//  - Collision: cfg_we level=0 mode=1 in the window-end cycle -> idx=0, win_err unchanged, new window starts clean.

Source files
------------

// File: rtl/approx_level_ctrl_if.sv
// approx_level_ctrl_if: config, sample and level-update bundle between the core and approx_level_ctrl
interface approx_level_ctrl_if #(parameter int ERR_W = 16);
    logic             cfg_we;
    logic             cfg_mode;
    logic [1:0]       cfg_level;
    logic [ERR_W-1:0] cfg_hi_th;
    logic [ERR_W-1:0] cfg_lo_th;
    logic             smp_valid;
    logic [31:0]      smp_a;
    logic [31:0]      smp_b;
    logic [31:0]      smp_sum;
    logic             upd_allow;
    logic [2:0]       approx_level;
    logic [1:0]       level_idx;
    logic             level_chg;
    logic [ERR_W-1:0] win_err;
    modport master (
        output cfg_we, cfg_mode, cfg_level, cfg_hi_th, cfg_lo_th,
        output smp_valid, smp_a, smp_b, smp_sum, upd_allow,
        input  approx_level, level_idx, level_chg, win_err
    );
    modport slave (
        input  cfg_we, cfg_mode, cfg_level, cfg_hi_th, cfg_lo_th,
        input  smp_valid, smp_a, smp_b, smp_sum, upd_allow,
        output approx_level, level_idx, level_chg, win_err
    );
endinterface

// File: rtl/approx_level_ctrl.sv
// approx_level_ctrl: picks the approximation level of the Sklansky carry tree, either
// fixed by config or adapted per window of checked adder samples.
module approx_level_ctrl #(
    parameter int WIN_LOG2 = 8,
    parameter int ERR_W    = 16
) (
    input logic               clk,
    input logic               rst,
    approx_level_ctrl_if.slave bus
);
    typedef enum logic [1:0] {FIXED, MONITOR, PEND} state_t;

    state_t              state, state_n;
    logic [1:0]          idx, idx_n, tgt, tgt_n;
    logic [ERR_W-1:0]    acc, acc_n, win, win_n, hi_th, lo_th, e_sum;
    logic [WIN_LOG2-1:0] cnt, cnt_n;
    logic                s1_v, s1_mis, chg;
    logic [2:0]          lvl;

    function automatic logic [2:0] ladder(input logic [1:0] i);
        return i == 2'd0 ? 3'b000 : i == 2'd1 ? 3'b001 : i == 2'd2 ? 3'b011 : 3'b111;
    endfunction

    always_comb begin
        e_sum   = acc == '1 ? acc : acc + ERR_W'(s1_mis);
        state_n = state;
        idx_n   = idx;
        tgt_n   = tgt;
        acc_n   = acc;
        cnt_n   = cnt;
        win_n   = win;
        if (bus.cfg_we) begin
            state_n = bus.cfg_mode ? MONITOR : FIXED;
            idx_n   = bus.cfg_level;
            tgt_n   = '0;
            acc_n   = '0;
            cnt_n   = '0;
        end else if (state == PEND) begin
            if (bus.upd_allow) begin
                idx_n   = tgt;
                state_n = MONITOR;
            end
        end else if (state == MONITOR && s1_v) begin
            acc_n = e_sum;
            cnt_n = cnt + WIN_LOG2'(1);
            if (cnt == '1) begin
                win_n = e_sum;
                acc_n = '0;
                cnt_n = '0;
                // hi threshold wins; a step off either end of the ladder is simply dropped
                if (e_sum > hi_th) begin
                    if (idx != 2'd0) begin
                        tgt_n   = idx - 2'd1;
                        state_n = PEND;
                    end
                end else if (e_sum < lo_th && idx != 2'd3) begin
                    tgt_n   = idx + 2'd1;
                    state_n = PEND;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FIXED;
            idx    <= '0;
            tgt    <= '0;
            acc    <= '0;
            cnt    <= '0;
            win    <= '0;
            hi_th  <= '0;
            lo_th  <= '0;
            s1_v   <= 1'b0;
            s1_mis <= 1'b0;
            lvl    <= '0;
            chg    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            tgt    <= tgt_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            win    <= win_n;
            hi_th  <= bus.cfg_we ? bus.cfg_hi_th : hi_th;
            lo_th  <= bus.cfg_we ? bus.cfg_lo_th : lo_th;
            s1_v   <= bus.smp_valid && state == MONITOR && !bus.cfg_we;
            s1_mis <= (bus.smp_a + bus.smp_b) != bus.smp_sum;
            lvl    <= ladder(idx_n);
            chg    <= idx_n != idx;
        end
    end

    assign bus.approx_level = lvl;
    assign bus.level_idx    = idx;
    assign bus.level_chg    = chg;
    assign bus.win_err      = win;
endmodule

// File: tb/tb_approx_level_ctrl.sv
// tb_approx_level_ctrl: scoreboard bench; expected level changes are queued as stimulus is
// driven and popped whenever the DUT raises level_chg.
module tb_approx_level_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  m_idx = 2'd0;
    logic [15:0] m_hi = '0, m_lo = '0;

    approx_level_ctrl_if #(.ERR_W(16)) bus();
    approx_level_ctrl #(.WIN_LOG2(2), .ERR_W(16)) dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ladder(input logic [1:0] i);
        return i == 2'd0 ? 3'b000 : i == 2'd1 ? 3'b001 : i == 2'd2 ? 3'b011 : 3'b111;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.level_chg) begin
            if (exp_q.size() == 0) chk("spurious_chg", 32'd1, 32'd0);
            else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("chg_idx", 32'(bus.level_idx), 32'(e));
                chk("chg_lvl", 32'(bus.approx_level), 32'(ladder(e)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic mode, input logic [1:0] lvl, input logic [15:0] hi, input logic [15:0] lo);
        bus.cfg_we    = 1'b1;
        bus.cfg_mode  = mode;
        bus.cfg_level = lvl;
        bus.cfg_hi_th = hi;
        bus.cfg_lo_th = lo;
        if (lvl != m_idx) exp_q.push_back(lvl);
        m_idx = lvl;
        m_hi  = hi;
        m_lo  = lo;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic drive_smp(input logic mis);
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        bus.smp_valid = 1'b1;
        bus.smp_a     = a;
        bus.smp_b     = b;
        bus.smp_sum   = a + b + 32'(mis);
    endtask

    task automatic drive_win(input logic [3:0] mis, output int e);
        e = 0;
        for (int k = 0; k < 4; k++) begin
            drive_smp(mis[k]);
            e += int'(mis[k]);
            tick();
        end
        bus.smp_valid = 1'b0;
    endtask

    function automatic bit decide(input int e);
        if (e > int'(m_hi)) begin
            if (m_idx == 2'd0) return 1'b0;
            m_idx = m_idx - 2'd1;
        end else if (e < int'(m_lo) && m_idx != 2'd3) m_idx = m_idx + 2'd1;
        else return 1'b0;
        exp_q.push_back(m_idx);
        return 1'b1;
    endfunction

    task automatic run_win(input string tag, input logic [3:0] mis);
        int e;
        bit ch;
        drive_win(mis, e);
        ch = decide(e);
        tick();
        @(negedge clk);
        chk({tag, "_win_err"}, 32'(bus.win_err), 32'(e));
        chk({tag, "_chg_t2"}, 32'(bus.level_chg), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_chg_t3"}, 32'(bus.level_chg), 32'(ch));
        chk({tag, "_idx_t3"}, 32'(bus.level_idx), 32'(m_idx));
        tick();
    endtask

    initial begin
        int e;
        bus.cfg_we = 0; bus.cfg_mode = 0; bus.cfg_level = 0; bus.cfg_hi_th = 0; bus.cfg_lo_th = 0;
        bus.smp_valid = 0; bus.smp_a = 0; bus.smp_b = 0; bus.smp_sum = 0; bus.upd_allow = 1;
        #1 rst = 1'b1;
        #1;
        chk("rst_lvl", 32'(bus.approx_level), 32'd0);
        chk("rst_win", 32'(bus.win_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // fixed mode: load, rewrite same level, samples ignored
        cfg(1'b0, 2'd2, 16'd0, 16'd0);
        @(negedge clk);
        chk("fix_chg", 32'(bus.level_chg), 32'd1);
        chk("fix_lvl", 32'(bus.approx_level), 32'b011);
        tick();
        cfg(1'b0, 2'd2, 16'd0, 16'd0);
        @(negedge clk);
        chk("fix_rewr_chg", 32'(bus.level_chg), 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive_smp(1'b1);
            tick();
        end
        bus.smp_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("fix_win_hold", 32'(bus.win_err), 32'd0);
        chk("fix_idx_hold", 32'(bus.level_idx), 32'd2);
        tick();

        cfg(1'b1, 2'd3, 16'd2, 16'd0);
        run_win("down", 4'hF);
        chk("down_lvl", 32'(bus.approx_level), 32'b011);

        cfg(1'b1, 2'd1, 16'd10, 16'd1);
        run_win("up", 4'h0);
        cfg(1'b1, 2'd3, 16'd10, 16'd1);
        run_win("top", 4'h0);

        // pending: grant withheld while samples keep streaming
        cfg(1'b1, 2'd3, 16'd2, 16'd0);
        bus.upd_allow = 1'b0;
        drive_win(4'hF, e);
        void'(decide(e));
        tick();
        @(negedge clk);
        chk("pend_win_err", 32'(bus.win_err), 32'(e));
        for (int k = 0; k < 20; k++) begin
            tick();
            drive_smp(k[0]);
            @(negedge clk);
            chk("pend_idx", 32'(bus.level_idx), 32'd3);
        end
        chk("pend_acc", 32'(dut.acc), 32'd0);
        chk("pend_cnt", 32'(dut.cnt), 32'd0);
        tick();
        bus.smp_valid = 1'b0;
        bus.upd_allow = 1'b1;
        tick();
        @(negedge clk);
        chk("pend_rel_chg", 32'(bus.level_chg), 32'd1);
        chk("pend_rel_idx", 32'(bus.level_idx), 32'd2);
        tick();

        // collision: config lands in the window-end cycle
        cfg(1'b1, 2'd3, 16'd10, 16'd0);
        run_win("pre", 4'b0001);
        drive_win(4'hF, e);
        cfg(1'b1, 2'd0, 16'd10, 16'd0);
        @(negedge clk);
        chk("col_win_err", 32'(bus.win_err), 32'd1);
        chk("col_idx", 32'(bus.level_idx), 32'd0);
        tick();
        run_win("post", 4'b0011);

        // async reset mid-window
        cfg(1'b1, 2'd3, 16'd10, 16'd0);
        drive_smp(1'b1);
        tick();
        drive_smp(1'b1);
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_lvl", 32'(bus.approx_level), 32'd0);
        chk("arst_idx", 32'(bus.level_idx), 32'd0);
        chk("arst_chg", 32'(bus.level_chg), 32'd0);
        chk("arst_win", 32'(bus.win_err), 32'd0);
        bus.smp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
